// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer for a word-wide memory without byte enables.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int RD_LAT    = 1,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        mem_readEn,
    output logic        mem_writeEn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_WriteData,
    input  logic [31:0] mem_ReadData,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken when req_valid=1 in IDLE; the pipeline holds it
    // while stall=1 and advances in the cycle resp_valid=1 (stall is low in DONE).
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [1:0]  lat_lo;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic        trap_now;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign trap_now = 1'b0;
`endif

    assign stall     = (state == IDLE && req_valid) || (state != IDLE && state != DONE);
    assign dbg_state = state;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        if (size == 2'b00)      return {{24{~uns & b[7]}}, b};
        else if (size == 2'b01) return {{16{~uns & h[15]}}, h};
        else                    return word;
    endfunction

    // Sub-word store: replace only the addressed lane of the word just read.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] m;
        m = word;
        if (size == 2'b00) begin
            case (lo)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end else if (lo[1]) begin
            m[31:16] = d[15:0];
        end else begin
            m[15:0] = d[15:0];
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            lat_lo        <= '0;
            lat_size      <= '0;
            lat_uns       <= 1'b0;
            lat_write     <= 1'b0;
            lat_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            misalign      <= 1'b0;
            mem_readEn    <= 1'b0;
            mem_writeEn   <= 1'b0;
            mem_address   <= '0;
            mem_WriteData <= '0;
        end else begin
            resp_valid <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_lo      <= req_addr[1:0];
                        lat_size    <= req_size;
                        lat_uns     <= req_unsigned;
                        lat_write   <= req_write;
                        lat_wdata   <= req_wdata;
                        mem_address <= {2'b00, req_addr[31:2]} % 32'(MEM_WORDS);
                        if (trap_now) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            misalign   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_size[1]) begin
                            state         <= WR;
                            mem_writeEn   <= 1'b1;
                            mem_WriteData <= req_wdata;
                        end else begin
                            state      <= RD_WAIT;
                            mem_readEn <= 1'b1;
                            lat_cnt    <= 4'(RD_LAT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        mem_readEn <= 1'b0;
                        if (lat_write) begin
                            state         <= WR;
                            mem_writeEn   <= 1'b1;
                            mem_WriteData <= merge(mem_ReadData, lat_size, lat_lo, lat_wdata);
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= extract(mem_ReadData, lat_size, lat_lo, lat_uns);
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                WR: begin
                    mem_writeEn <= 1'b0;
                    state       <= DONE;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= '0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a word-array reference model.
// Optionally compiled with LSU_MISALIGN_TRAP_EN to match a trapping DUT build.
module tb_load_store_unit;
    localparam int RD_LAT    = 2;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, misalign, mem_readEn, mem_writeEn;
    logic [31:0] resp_rdata, mem_address, mem_WriteData, mem_ReadData;
    logic [1:0]  dbg_state;

    load_store_unit #(.RD_LAT(RD_LAT), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .misalign(misalign), .mem_readEn(mem_readEn),
        .mem_writeEn(mem_writeEn), .mem_address(mem_address),
        .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory environment ----------------
    logic [31:0] mem_arr [MEM_WORDS];
    assign mem_ReadData = mem_arr[mem_address % MEM_WORDS];
    always @(negedge clk) if (mem_writeEn) mem_arr[mem_address % MEM_WORDS] <= mem_WriteData;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [MEM_WORDS];

    function automatic logic [31:0] widx(input logic [31:0] a);
        return (a >> 2) % MEM_WORDS;
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (size == 2'd1 && a[0]) || (size >= 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [31:0] a, input logic uns);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            v = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            sh = a[1] ? 16 : 0;
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((d & 32'hFF) << sh);
        end else if (size == 2'd1) begin
            sh = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] cyc;
    } exp_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_readEn || mem_writeEn)
                chk("rd_wr_exclusive", {31'd0, mem_readEn & mem_writeEn}, 32'd0);
            if (mem_writeEn) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_address, w.addr);
                    chk("wr_data", mem_WriteData, w.data);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    chk("latency_cycle", cyc, e.cyc);
                    chk("stall_in_done", {31'd0, stall}, 32'd0);
                end
            end else if (misalign) begin
                chk("stray_misalign", 32'd1, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic w, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] idx, nw;
        int          lat;
        bit          done;
        @(negedge clk);
        idx = widx(addr);
        if (is_mis(size, addr)) begin
            e.rdata = 32'd0; e.mis = 1'b1; lat = 1;
        end else if (!w) begin
            e.rdata = ref_load(ref_mem[idx], size, addr, uns); e.mis = 1'b0; lat = RD_LAT + 1;
        end else begin
            nw = ref_store(ref_mem[idx], size, addr, wdata);
            wr_q.push_back({idx, nw});
            ref_mem[idx] = nw;
            e.rdata = 32'd0; e.mis = 1'b0;
            lat = (size >= 2'd2) ? 2 : RD_LAT + 2;
        end
        e.cyc = cyc + 32'(lat);
        exp_q.push_back(e);
        req_write = w; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && lat > 1) chk("stall_busy", {31'd0, stall}, 32'd1);
            if (resp_valid) done = 1'b1;
        end
        chk("resp_timeout", {31'd0, done}, 32'd1);
        if (!done) begin
            exp_q.delete();
            wr_q.delete();
        end
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_readEn"}, {31'd0, mem_readEn}, 32'd0);
        chk({tag, "_writeEn"}, {31'd0, mem_writeEn}, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_address"}, mem_address, 32'd0);
        chk({tag, "_wdata"}, mem_WriteData, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_arr[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        #2 rst = 1'b1;

        // word store / load round trip
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // byte lanes with sign and zero extension
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) do_req(1'b0, 2'd0, 1'b0, 32'h10 + 32'(i), 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        // byte store read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // halfword store onto a zero word, then loads
        do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        // misaligned word load and halfword
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h17, 32'h0);

        // reset in the middle of a sub-word store's read phase: no write may land
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h55; req_valid = 1'b1;
        @(negedge clk);
        chk("mid_rmw_readEn", {31'd0, mem_readEn}, 32'd1);
        rst = 1'b0; req_valid = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clk);
        #2 rst = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // randomized traffic, including addresses that wrap the memory depth
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 511));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom());
        end

        repeat (4) @(negedge clk);
        chk("leftover_resp", 32'(exp_q.size()), 32'd0);
        chk("leftover_write", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the 32-bit pipeline; drives the word-wide data memory's readEn/writeEn/address/WriteData/ReadData interface.
- Accepts one load or store per request from the pipeline and sequences the memory access.
- Performs byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores, because the memory has no byte enables.
- Asserts stall until the access completes.

Parameters:
- RD_LAT, 1, cycles from readEn/address assertion to ReadData sampled (1..15).
- MEM_WORDS, 1024, memory depth in 32-bit words; mem_address carries the word index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from MEM stage; held stable by pipeline while stall=1.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=halfword, 10=word; 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data in low bits.
- stall  out  1  freeze pipeline.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; valid with resp_valid.
- misalign  out  1  one-cycle pulse with resp_valid on a trapped misaligned access.
- mem_readEn  out  1  memory read enable.
- mem_writeEn  out  1  memory write enable; memory commits on negedge.
- mem_address  out  32  word index = {2'b00, req_addr[31:2]} taken modulo MEM_WORDS.
- mem_WriteData  out  32  full word to write.
- mem_ReadData  in  32  memory read word.

Behaviour:
- Reset (rst=0, async): state=IDLE; stall, resp_valid, misalign, mem_readEn and mem_writeEn=0; resp_rdata, mem_address and mem_WriteData=0; latency counter=0.
- Reset mid-operation aborts the access with no write. mem_writeEn drops immediately, so a pending negedge commit is suppressed.
- stall = (state==IDLE & req_valid) | (state!=IDLE & state!=DONE). It is combinational and low in DONE, so the pipeline advances on the cycle resp_valid=1.
- IDLE: on req_valid, latch addr, size, unsigned flag, write flag and wdata. Next state:
  - word store -> WR
  - load or sub-word store -> RD_WAIT, with counter loaded to RD_LAT-1.
- RD_WAIT: mem_readEn=1 and mem_address=latched word index. Counter decrements each cycle. When it reaches 0, sample mem_ReadData into rd_word, then:
  - load -> DONE
  - sub-word store -> WR
- WR: mem_writeEn=1 for exactly one cycle; mem_WriteData is the merged word.
  - Word store: wdata.
  - Byte store: rd_word with byte lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: lane addr[1] replaced by wdata[15:0].
  - Next state: DONE.
- DONE: resp_valid=1 for one cycle.
  - Load: resp_rdata = lane extracted from rd_word (lane 0 = bits 7:0, little-endian), extended per req_unsigned.
  - Store: resp_rdata=0.
  - Next state: IDLE. A new request is accepted no earlier than the following cycle.
- readEn and writeEn are never both 1. mem_address is held stable for the full RD_WAIT+WR sequence.
- Latency, accept cycle to resp_valid:
  - load: RD_LAT+1
  - word store: 2
  - sub-word store: RD_LAT+2
- req_valid deasserting while stall=1 is a protocol violation; the LSU completes using latched values.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 goes IDLE->DONE with no memory access. In DONE: misalign=1, resp_valid=1, resp_rdata=0.
- Undefined: misaligned accesses are force-aligned (halfword uses addr[1] only; word ignores addr[1:0]). misalign is tied 0.

Test Plan:
- Reset: hold rst=0 mid-RD_WAIT -> all outputs 0; state returns to IDLE with no write issued; first request after rst=1 accepted normally.
- Word store then load, RD_LAT=1: store 0xDEADBEEF at addr 0x10 -> mem_writeEn one cycle, mem_address=4, resp_valid 2 cycles after accept. Load same addr -> resp_rdata=0xDEADBEEF at cycle 2.
- Signed byte load: memory word 4 = 0x80FF7F01. Loads at 0x10/0x11/0x12/0x13 (signed) -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Unsigned at 0x13 -> 0x00000080.
- Byte store RMW: word 4 = 0x11223344; store byte 0xAA at 0x12 -> mem_WriteData=0x11AA3344; readEn precedes writeEn; latency RD_LAT+2.
- Halfword store/load: store 0xBEEF at 0x16 onto 0x00000000 -> word 5 = 0xBEEF0000. Signed halfword load at 0x16 -> 0xFFFFBEEF.
- Misaligned, with LSU_MISALIGN_TRAP_EN: word load at 0x11 -> misalign=1 and resp_valid=1 one cycle after accept, no readEn. Without the macro: the same load returns word 4.
